// File: rtl/ex_mem_stage_if.sv
// Bundle of ID/EX inputs and EX/MEM outputs for the execute stage.
// master drives the instruction side; slave is the execute stage itself.
interface ex_mem_stage_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    logic [3:0]            i_alu_ctl;
    logic [DATA_W-1:0]     i_rs_data;
    logic [DATA_W-1:0]     i_rt_data;
    logic [DATA_W-1:0]     i_imm;
    logic                  i_alu_src;
    logic [4:0]            i_shamt;
    logic [DATA_W-1:0]     i_link_pc;
    logic [REG_ADDR_W-1:0] i_dst_addr;
    logic                  i_reg_write;
    logic                  i_mem_read;
    logic                  i_mem_write;
    logic                  i_mem_to_reg;
    logic                  i_valid;
    logic                  i_stall;
    logic                  i_flush;
    logic [1:0]            i_fwd_a;
    logic [1:0]            i_fwd_b;
    logic [DATA_W-1:0]     i_mem_fwd_data;
    logic [DATA_W-1:0]     i_wb_fwd_data;

    logic [DATA_W-1:0]     o_alu_result;
    logic                  o_zero;
    logic [DATA_W-1:0]     o_store_data;
    logic [REG_ADDR_W-1:0] o_dst_addr;
    logic                  o_reg_write;
    logic                  o_mem_read;
    logic                  o_mem_write;
    logic                  o_mem_to_reg;
    logic                  o_valid;

    modport master (
        output i_alu_ctl, i_rs_data, i_rt_data, i_imm, i_alu_src, i_shamt,
               i_link_pc, i_dst_addr, i_reg_write, i_mem_read, i_mem_write,
               i_mem_to_reg, i_valid, i_stall, i_flush, i_fwd_a, i_fwd_b,
               i_mem_fwd_data, i_wb_fwd_data,
        input  o_alu_result, o_zero, o_store_data, o_dst_addr, o_reg_write,
               o_mem_read, o_mem_write, o_mem_to_reg, o_valid
    );

    modport slave (
        input  i_alu_ctl, i_rs_data, i_rt_data, i_imm, i_alu_src, i_shamt,
               i_link_pc, i_dst_addr, i_reg_write, i_mem_read, i_mem_write,
               i_mem_to_reg, i_valid, i_stall, i_flush, i_fwd_a, i_fwd_b,
               i_mem_fwd_data, i_wb_fwd_data,
        output o_alu_result, o_zero, o_store_data, o_dst_addr, o_reg_write,
               o_mem_read, o_mem_write, o_mem_to_reg, o_valid
    );
endinterface

// File: rtl/ex_mem_stage.sv
// MIPS execute stage (forward mux, ALU) plus EX/MEM pipeline register.
// Operand forwarding is enabled by defining EX_FWD_EN.
module ex_mem_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    ex_mem_stage_if.slave  bus
);

    logic [DATA_W-1:0]     op_a;
    logic [DATA_W-1:0]     op_bf;
    logic [DATA_W-1:0]     op_b;
    logic [DATA_W-1:0]     result;
    logic                  zero;

    logic [DATA_W-1:0]     result_q;
    logic                  zero_q;
    logic [DATA_W-1:0]     store_q;
    logic [REG_ADDR_W-1:0] dst_q;
    logic                  reg_write_q;
    logic                  mem_read_q;
    logic                  mem_write_q;
    logic                  mem_to_reg_q;
    logic                  valid_q;

`ifdef EX_FWD_EN
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] idex,
        input logic [DATA_W-1:0] mem,
        input logic [DATA_W-1:0] wb
    );
        case (sel)
            2'b01:   return mem;
            2'b10:   return wb;
            default: return idex;
        endcase
    endfunction

    assign op_a  = fwd_sel(bus.i_fwd_a, bus.i_rs_data, bus.i_mem_fwd_data, bus.i_wb_fwd_data);
    assign op_bf = fwd_sel(bus.i_fwd_b, bus.i_rt_data, bus.i_mem_fwd_data, bus.i_wb_fwd_data);
`else
    // Forward ports stay on the interface but have no effect in this build.
    logic unused_fwd;
    assign unused_fwd = ^{bus.i_fwd_a, bus.i_fwd_b, bus.i_mem_fwd_data, bus.i_wb_fwd_data};
    assign op_a  = bus.i_rs_data;
    assign op_bf = bus.i_rt_data;
`endif

    assign op_b = bus.i_alu_src ? bus.i_imm : op_bf;

    always_comb begin
        result = '0;
        case (bus.i_alu_ctl)
            4'd0:    result = op_a & op_b;
            4'd1:    result = op_a | op_b;
            4'd2:    result = op_a + op_b;
            4'd3:    result = ~(op_a | op_b);
            4'd4:    result = op_a ^ op_b;
            4'd5:    result = op_b << bus.i_shamt;
            4'd6:    result = op_a - op_b;
            4'd7:    result = ($signed(op_a) < $signed(op_b)) ? DATA_W'(1) : '0;
            4'd8:    result = {op_b[15:0], {(DATA_W-16){1'b0}}};
            4'd9:    result = op_b << op_a[4:0];
            4'd10:   result = op_b >> bus.i_shamt;
            4'd11:   result = op_b >> op_a[4:0];
            4'd12:   result = $signed(op_b) >>> bus.i_shamt;
            4'd13:   result = $signed(op_b) >>> op_a[4:0];
            4'd15:   result = bus.i_link_pc;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

    // Flush outranks stall so a squashed instruction never lingers in MEM.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || bus.i_flush) begin
            result_q     <= '0;
            zero_q       <= 1'b0;
            store_q      <= '0;
            dst_q        <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            valid_q      <= 1'b0;
        end else if (!bus.i_stall) begin
            result_q     <= result;
            zero_q       <= zero;
            store_q      <= op_bf;
            dst_q        <= bus.i_dst_addr;
            reg_write_q  <= bus.i_reg_write  & bus.i_valid;
            mem_read_q   <= bus.i_mem_read   & bus.i_valid;
            mem_write_q  <= bus.i_mem_write  & bus.i_valid;
            mem_to_reg_q <= bus.i_mem_to_reg & bus.i_valid;
            valid_q      <= bus.i_valid;
        end
    end

    assign bus.o_alu_result = result_q;
    assign bus.o_zero       = zero_q;
    assign bus.o_store_data = store_q;
    assign bus.o_dst_addr   = dst_q;
    assign bus.o_reg_write  = reg_write_q;
    assign bus.o_mem_read   = mem_read_q;
    assign bus.o_mem_write  = mem_write_q;
    assign bus.o_mem_to_reg = mem_to_reg_q;
    assign bus.o_valid      = valid_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed steps followed by random traffic
// checked against an arithmetic reference of the execute stage and register.
module tb_ex_mem_stage;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    ex_mem_stage_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

    ex_mem_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] m_result, m_store;
    logic        m_zero, m_rw, m_mr, m_mw, m_mtr, m_valid;
    logic [4:0]  m_dst;

    function automatic longint floor_shift(input longint v, input int s);
        longint d;
        d = longint'(1) << s;
        if (v < 0) return (v - (d - 1)) / d;
        return v / d;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] code, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh,
                                            input logic [31:0] link);
        longint ua, ub, sb, r;
        logic [63:0] rr;
        ua = longint'(a);
        ub = longint'(b);
        sb = longint'($signed(b));
        case (code)
            4'd0:  r = ua & ub;
            4'd1:  r = ua | ub;
            4'd2:  r = ua + ub;
            4'd3:  r = ~(ua | ub);
            4'd4:  r = ua ^ ub;
            4'd5:  r = ub * (longint'(1) << sh);
            4'd6:  r = ua - ub;
            4'd7:  r = ($signed(a) < $signed(b)) ? 1 : 0;
            4'd8:  r = (ub % 65536) * 65536;
            4'd9:  r = ub * (longint'(1) << a[4:0]);
            4'd10: r = ub / (longint'(1) << sh);
            4'd11: r = ub / (longint'(1) << a[4:0]);
            4'd12: r = floor_shift(sb, int'(sh));
            4'd13: r = floor_shift(sb, int'(a[4:0]));
            4'd15: r = ua ^ ua ^ longint'(link);
            default: r = 0;
        endcase
        rr = r;
        return rr[31:0];
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] idex);
`ifdef EX_FWD_EN
        if (sel == 2'd1) return bus.i_mem_fwd_data;
        if (sel == 2'd2) return bus.i_wb_fwd_data;
`endif
        return idex ^ {30'b0, sel & 2'b00};
    endfunction

    task automatic model_edge();
        logic [31:0] a, bf, b;
        if (!rst_n || bus.i_flush) begin
            m_result = 0; m_zero = 0; m_store = 0; m_dst = 0;
            m_rw = 0; m_mr = 0; m_mw = 0; m_mtr = 0; m_valid = 0;
        end else if (!bus.i_stall) begin
            a  = ref_fwd(bus.i_fwd_a, bus.i_rs_data);
            bf = ref_fwd(bus.i_fwd_b, bus.i_rt_data);
            b  = bus.i_alu_src ? bus.i_imm : bf;
            m_result = ref_alu(bus.i_alu_ctl, a, b, bus.i_shamt, bus.i_link_pc);
            m_zero   = (m_result == 0);
            m_store  = bf;
            m_dst    = bus.i_dst_addr;
            m_valid  = bus.i_valid;
            m_rw     = bus.i_valid ? bus.i_reg_write  : 1'b0;
            m_mr     = bus.i_valid ? bus.i_mem_read   : 1'b0;
            m_mw     = bus.i_valid ? bus.i_mem_write  : 1'b0;
            m_mtr    = bus.i_valid ? bus.i_mem_to_reg : 1'b0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".result"},     bus.o_alu_result,         m_result);
        check({tag, ".zero"},       32'(bus.o_zero),          32'(m_zero));
        check({tag, ".store"},      bus.o_store_data,         m_store);
        check({tag, ".dst"},        32'(bus.o_dst_addr),      32'(m_dst));
        check({tag, ".reg_write"},  32'(bus.o_reg_write),     32'(m_rw));
        check({tag, ".mem_read"},   32'(bus.o_mem_read),      32'(m_mr));
        check({tag, ".mem_write"},  32'(bus.o_mem_write),     32'(m_mw));
        check({tag, ".mem_to_reg"}, 32'(bus.o_mem_to_reg),    32'(m_mtr));
        check({tag, ".valid"},      32'(bus.o_valid),         32'(m_valid));
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic randomize_inputs();
        bus.i_alu_ctl      = 4'($urandom_range(0, 15));
        bus.i_rs_data      = $urandom;
        bus.i_rt_data      = ($urandom_range(0, 3) == 0) ? bus.i_rs_data : $urandom;
        bus.i_imm          = $urandom;
        bus.i_alu_src      = 1'($urandom);
        bus.i_shamt        = 5'($urandom);
        bus.i_link_pc      = $urandom;
        bus.i_dst_addr     = 5'($urandom);
        bus.i_reg_write    = 1'($urandom);
        bus.i_mem_read     = 1'($urandom);
        bus.i_mem_write    = 1'($urandom);
        bus.i_mem_to_reg   = 1'($urandom);
        bus.i_valid        = ($urandom_range(0, 4) != 0);
        bus.i_stall        = ($urandom_range(0, 9) == 0);
        bus.i_flush        = ($urandom_range(0, 19) == 0);
        bus.i_fwd_a        = 2'($urandom);
        bus.i_fwd_b        = 2'($urandom);
        bus.i_mem_fwd_data = $urandom;
        bus.i_wb_fwd_data  = $urandom;
    endtask

    task automatic set_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
        bus.i_alu_ctl = code; bus.i_rs_data = a; bus.i_rt_data = b;
        bus.i_alu_src = 0; bus.i_stall = 0; bus.i_flush = 0; bus.i_valid = 1;
        bus.i_fwd_a = 0; bus.i_fwd_b = 0;
    endtask

    initial begin
        randomize_inputs();
        rst_n = 1'b0;
        bus.i_stall = 1'b1;
        tick("reset");
        check("reset.valid_zero", 32'(bus.o_valid), 32'd0);

        rst_n = 1'b1;
        bus.i_reg_write = 1;
        set_op(4'd2, 32'd5, 32'd7);
        tick("add");
        check("add.12", bus.o_alu_result, 32'd12);
        check("add.zero0", 32'(bus.o_zero), 32'd0);
        check("add.valid1", 32'(bus.o_valid), 32'd1);

        set_op(4'd6, 32'hFFFF_FFF0, 32'h0000_0010);
        bus.i_shamt = 5'd4;
        tick("sub");
        check("sub.val", bus.o_alu_result, 32'hFFFF_FFE0);
        set_op(4'd7, 32'hFFFF_FFF0, 32'h0000_0010);
        tick("slt");
        check("slt.val", bus.o_alu_result, 32'd1);
        set_op(4'd12, 32'hFFFF_FFF0, 32'h8000_0000);
        tick("sra");
        check("sra.val", bus.o_alu_result, 32'hF800_0000);
        set_op(4'd10, 32'hFFFF_FFF0, 32'h8000_0000);
        tick("srl");
        check("srl.val", bus.o_alu_result, 32'h0800_0000);
        set_op(4'd8, 32'd0, 32'd0);
        bus.i_alu_src = 1; bus.i_imm = 32'h0000_1234;
        tick("lui");
        check("lui.val", bus.o_alu_result, 32'h1234_0000);
        set_op(4'd15, 32'd9, 32'd9);
        bus.i_link_pc = 32'h100;
        tick("link");
        check("link.val", bus.o_alu_result, 32'h100);

        set_op(4'd6, 32'h55, 32'h55);
        tick("beq");
        check("beq.zero1", 32'(bus.o_zero), 32'd1);

        set_op(4'd2, 32'd1, 32'd1);
        tick("pre_stall");
        check("pre_stall.2", bus.o_alu_result, 32'd2);
        for (int i = 0; i < 3; i++) begin
            set_op(4'd2, $urandom, $urandom);
            bus.i_stall = 1;
            tick("stall");
            check("stall.hold2", bus.o_alu_result, 32'd2);
        end
        bus.i_flush = 1;
        tick("stall_flush");
        check("stall_flush.valid0", 32'(bus.o_valid), 32'd0);

        set_op(4'd2, 32'd3, 32'd4);
        bus.i_valid = 0; bus.i_reg_write = 1; bus.i_mem_write = 1;
        tick("invalid");
        check("invalid.rw0", 32'(bus.o_reg_write), 32'd0);
        check("invalid.mw0", 32'(bus.o_mem_write), 32'd0);

        set_op(4'd2, 32'd1, 32'd3);
        bus.i_mem_fwd_data = 32'd10; bus.i_wb_fwd_data = 32'd20;
        bus.i_fwd_a = 2'b01; bus.i_fwd_b = 2'b10;
        tick("fwd");
`ifdef EX_FWD_EN
        check("fwd.result", bus.o_alu_result, 32'd30);
        check("fwd.store", bus.o_store_data, 32'd20);
`else
        check("fwd.result", bus.o_alu_result, 32'd4);
        check("fwd.store", bus.o_store_data, 32'd3);
`endif

        set_op(4'd2, 32'd8, 32'd8);
        tick("pre_rst");
        bus.i_stall = 1;
        rst_n = 0;
        tick("rst_in_stall");
        check("rst_in_stall.result0", bus.o_alu_result, 32'd0);
        rst_n = 1;

        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            rst_n = ($urandom_range(0, 29) != 0);
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute stage plus EX/MEM pipeline register of the MIPS core. Consumes the 4-bit `ALUCtl` code produced by ALU control, selects and optionally forwards operands, computes the ALU result and zero flag, and registers the result together with the memory/writeback control bits for the MEM stage. Supports pipeline stall (hold) and flush (bubble insert).

## Interface
- `DATA_W`, 32, datapath width (shift/LUI semantics fixed for 32)
- `REG_ADDR_W`, 5, register-file address width
- `i_clk` in 1: clock; all state updates on rising edge
- `i_rst_n` in 1: reset, synchronous, active-low
- `i_alu_ctl` in 4: operation code from ALU control
- `i_rs_data`, `i_rt_data` in DATA_W: ID/EX register operands
- `i_imm` in DATA_W: sign/zero-extended immediate
- `i_alu_src` in 1: 1 = operand B is `i_imm`, 0 = forwarded rt
- `i_shamt` in 5: shift amount for SLL/SRL/SRA
- `i_link_pc` in DATA_W: return address (PC+8) for JAL/JALR
- `i_dst_addr` in REG_ADDR_W: destination register
- `i_reg_write`, `i_mem_read`, `i_mem_write`, `i_mem_to_reg` in 1 each: control bits
- `i_valid` in 1: ID/EX holds a real instruction
- `i_stall` in 1: hold EX/MEM register
- `i_flush` in 1: load bubble into EX/MEM register
- `i_fwd_a`, `i_fwd_b` in 2: forward selects (see Configuration)
- `i_mem_fwd_data`, `i_wb_fwd_data` in DATA_W: forwarded values
- `o_alu_result` out DATA_W; `o_zero` out 1; `o_store_data` out DATA_W
- `o_dst_addr` out REG_ADDR_W; `o_reg_write`, `o_mem_read`, `o_mem_write`, `o_mem_to_reg`, `o_valid` out 1 each

## Operation
- A = forwarded rs; Bf = forwarded rt; B = `i_alu_src` ? `i_imm` : Bf.
- Result by code: 0 A&B; 1 A|B; 2 A+B (mod 2^32, no trap); 3 ~(A|B); 4 A^B; 5 B<<shamt; 6 A−B; 7 signed(A)<signed(B) ? 1 : 0; 8 {B[15:0],16'h0}; 9 B<<A[4:0]; 10 B>>shamt logical; 11 B>>A[4:0] logical; 12 B>>>shamt arithmetic; 13 B>>>A[4:0] arithmetic; 14 result 0; 15 `i_link_pc`.
- Shifts use the low 5 bits only; larger amounts impossible.
- Zero flag = (result == 0), computed combinationally, registered with result.
- Store data = Bf (forwarded rt, never immediate).
- Register update priority per edge: reset > flush > stall > load.
  - Reset/flush: all outputs 0.
  - Stall: all outputs hold, including `o_valid`.
  - Load: capture result, zero, store data, `i_dst_addr`, control bits ANDed with `i_valid`; `o_valid` = `i_valid`.
- `i_valid`=0 on load: control outputs 0 regardless of their inputs; data outputs still captured (don't-care).

## Timing
- Latency 1 cycle: inputs at edge N visible on outputs after edge N.
- Combinational path: forward mux -> alu_src mux -> ALU -> register; no combinational input-to-output path.
- Reset value of every output: 0.
- Flush and stall same cycle: flush wins.
- Reset asserted mid-stall: outputs 0 next edge; stall ignored.
- Back-to-back loads: new value every cycle, no bubbles inserted by the block.

## Configuration
- `EX_FWD_EN` defined: `i_fwd_a`/`i_fwd_b` select 00 ID/EX operand, 01 `i_mem_fwd_data`, 10 `i_wb_fwd_data`, 11 ID/EX operand.
- Not defined: forward ports remain present but ignored; A = `i_rs_data`, Bf = `i_rt_data` always.

## Test plan
- Reset: `i_rst_n`=0 with arbitrary inputs -> all outputs 0 after edge; release, load ADD A=5 B=7 -> `o_alu_result`=12, `o_zero`=0, `o_valid`=1.
- Arithmetic/shift sweep: A=0xFFFF_FFF0, B=0x0000_0010, shamt=4 -> SUB 0xFFFF_FFE0, SLT 1, SRA of B=0x8000_0000 by 4 -> 0xF800_0000, SRL -> 0x0800_0000, LUI imm 0x1234 -> 0x1234_0000, code 15 link 0x100 -> 0x100.
- Branch compare: SUB A=B=0x55 -> result 0, `o_zero`=1.
- Stall/flush: load ADD 1+1 (=2), then stall 3 cycles with new inputs -> output stays 2; stall+flush together -> all outputs 0, `o_valid`=0.
- Invalid instruction: `i_valid`=0 with `i_reg_write`=`i_mem_write`=1 -> `o_reg_write`=`o_mem_write`=0, `o_valid`=0.
- Forwarding (`EX_FWD_EN`): rs=1, mem_fwd=10, wb_fwd=20, rt=3, ADD, fwd_a=01 fwd_b=10 -> 30, store data 20; without macro same stimulus -> 4, store data 3.
